// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray/binary conversion helpers and counter step encoding for gray_counter_param.
package gray_pkg;
  localparam int GRAY_MAX_W = 64;
  typedef logic [GRAY_MAX_W-1:0] gword_t;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_UP, OP_DN} op_e;
  function automatic gword_t bin2gray(input gword_t b);
    return b ^ (b >> 1);
  endfunction
  // Prefix XOR from the MSB down; zero-extended inputs convert correctly at any narrower width.
  function automatic gword_t gray2bin(input gword_t g);
    gword_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic int unsigned popcount(input gword_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < GRAY_MAX_W; i++) n += 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/bin_counter_core.sv
// bin_counter_core: binary up/down/load counter with wrap or saturate at the bounds.
module bin_counter_core
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_bin_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             tc_o
);
  op_e              op;
  logic             at_bound;
  logic [WIDTH-1:0] bin_q, bin_d, stepped;
  // A step attempted at the bound is both the wrap event and the saturation event.
  always_comb begin
    op       = load ? OP_LOAD : en ? (up ? OP_UP : OP_DN) : OP_HOLD;
    at_bound = (op == OP_UP && &bin_q) || (op == OP_DN && ~|bin_q);
    stepped  = op == OP_UP ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
    bin_d    = op == OP_LOAD ? load_val :
               op == OP_HOLD ? bin_q :
               (SATURATE && at_bound) ? bin_q : stepped;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bin_q <= '0;
    else          bin_q <= bin_d;
  end
  assign next_bin_o = bin_d;
  assign bin_o      = bin_q;
  assign tc_o       = at_bound;
endmodule

// File: rtl/gray_counter_param.sv
// gray_counter_param: registered up/down Gray counter with load and terminal-count pulse.
// Define GRAY_CNT_CHECK_EN to build the sticky one-bit-change checker driving err.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             err
);
  logic [WIDTH-1:0] next_bin, gray_d, gray_q;
  logic             tc_d, tc_q;
  bin_counter_core #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .next_bin_o(next_bin),
    .bin_o     (bin_out),
    .tc_o      (tc_d)
  );
  // Encoding the next binary value before the register keeps gray_out glitch-free.
  assign gray_d = WIDTH'(bin2gray(gword_t'(next_bin)));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end
  assign gray_out = gray_q;
  assign tc       = tc_q;
`ifdef GRAY_CNT_CHECK_EN
  logic err_d, err_q, step, bad;
  always_comb begin
    step  = en && !load && next_bin != bin_out;
    bad   = popcount(gword_t'(gray_q ^ gray_d)) != 1 ||
            WIDTH'(gray2bin(gword_t'(gray_q))) != bin_out;
    err_d = err_q || (step && bad);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_counter_param.sv
// tb_gray_counter_param: directed checks of wrap and saturating 4-bit instances against an integer model.
module tb_gray_counter_param;
  logic       clk = 1'b0, reset_n = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] g0, b0, g1, b1;
  logic       tc0, tc1, e0, e1;
  int         total = 0, passed = 0;
  bit         chk_on = 1'b0, inj = 1'b0;
  int         m0 = 0, m1 = 0;
  bit         t0 = 1'b0, t1 = 1'b0;
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) d0 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray_out(g0), .bin_out(b0), .tc(tc0), .err(e0));
  gray_counter_param #(.WIDTH(4), .SATURATE(1'b1)) d1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray_out(g1), .bin_out(b1), .tc(tc1), .err(e1));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  task automatic cyc(input bit e, input bit u, input bit l, input logic [3:0] v);
    en = e; up = u; load = l; load_val = v;
    @(negedge clk);
  endtask

  always @(posedge clk or negedge reset_n) begin
    int s, r;
    if (!reset_n) begin
      m0 = 0; m1 = 0; t0 = 0; t1 = 0;
    end else if (load) begin
      m0 = int'(load_val); m1 = int'(load_val); t0 = 0; t1 = 0;
    end else if (!en) begin
      t0 = 0; t1 = 0;
    end else begin
      s = up ? 1 : -1;
      r = m0 + s; t0 = (r < 0 || r > 15); m0 = (r + 16) % 16;
      r = m1 + s; t1 = (r < 0 || r > 15); m1 = t1 ? m1 : r;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("bin0", int'(b0), m0);
      chk("gray0", int'(g0), gray_of(m0));
      chk("tc0", int'(tc0), int'(t0));
      chk("err0", int'(e0), int'(inj));
      chk("bin1", int'(b1), m1);
      chk("gray1", int'(g1), gray_of(m1));
      chk("tc1", int'(tc1), int'(t1));
      chk("err1", int'(e1), 0);
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("rst_async_bin", int'(b0), 0);
    chk("rst_async_gray", int'(g0), 0);
    chk("rst_async_tc", int'(tc1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    chk_on = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 1, 0, 4'h0);
      chk("upseq_gray", int'(g0), int'(gtab[k % 16]));
      chk("upseq_tc", int'(tc0), int'(k == 16));
    end
    chk("sat_bin", int'(b1), 15);
    chk("sat_tc", int'(tc1), 1);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 1, 0, 4'h0);
      chk("sat_hold_gray", int'(g1), 4'b1000);
      chk("sat_hold_tc", int'(tc1), 1);
    end
    cyc(1, 0, 0, 4'h0);
    chk("sat_down_bin", int'(b1), 4'b1110);
    chk("sat_down_tc", int'(tc1), 0);
    cyc(1, 1, 1, 4'b1010);
    chk("load_bin", int'(b0), 4'b1010);
    chk("load_gray", int'(g0), 4'b1111);
    chk("load_tc", int'(tc1), 0);
    cyc(1, 1, 0, 4'h0);
    chk("post_load_bin", int'(b0), 4'b1011);
    chk("post_load_gray", int'(g0), 4'b1110);
    cyc(0, 0, 1, 4'h0);
    cyc(1, 0, 0, 4'h0);
    chk("dnwrap_bin", int'(b0), 4'b1111);
    chk("dnwrap_gray", int'(g0), 4'b1000);
    chk("dnwrap_tc", int'(tc0), 1);
    chk("dnsat_tc", int'(tc1), 1);
    cyc(1, 0, 0, 4'h0);
    chk("dn2_bin", int'(b0), 4'b1110);
    chk("dn2_gray", int'(g0), 4'b1001);
    chk("dn2_tc", int'(tc0), 0);
    cyc(0, 1, 0, 4'h0);
    chk("hold_bin", int'(b0), 4'b1110);
    cyc(0, 0, 1, 4'b1110);
    chk("load_same_tc", int'(tc0), 0);
    cyc(1, 1, 0, 4'h0);
    cyc(1, 0, 0, 4'h0);
    chk("turnaround_bin", int'(b0), 4'b1110);
    cyc(0, 0, 1, 4'b0110);
    chk("pre_rst_gray", int'(g0), 4'b0101);
    en = 1'b1; up = 1'b1; load = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_bin", int'(b0), 0);
    chk("midrst_gray", int'(g0), 0);
    chk("midrst_tc", int'(tc0), 0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1, 1, 0, 4'h0);
    chk("rst_release_gray", int'(g0), 4'b0001);
`ifdef GRAY_CNT_CHECK_EN
    cyc(0, 0, 1, 4'h2);
    chk_on = 1'b0;
    force d0.gray_q = 4'b0101;
    cyc(1, 1, 0, 4'h0);
    release d0.gray_q;
    inj = 1'b1;
    cyc(1, 1, 0, 4'h0);
    chk_on = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 4'h0);
    chk("err_sticky", int'(e0), 1);
    reset_n = 1'b0;
    #1;
    chk("err_cleared", int'(e0), 0);
    inj = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
`else
    chk("err_tied", int'(e0), 0);
`endif
    for (int i = 1; i < 60; i++)
      cyc(i % 5 != 0, i % 7 < 4, i % 11 == 0, 4'(i));
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
